// File: rtl/mult_fu.sv
// mult_fu: pipelined RV32M integer multiply functional unit.
//
// Takes one issued multiply per cycle from the reservation station and
// computes MUL / MULH / MULHSU / MULHU over STAGES pipeline stages. Each
// stage folds XLEN/STAGES bits of rs2 partial products into a 2*XLEN
// accumulator. The last stage is the output register, which holds the
// result until the CDB arbiter grants it. Every in-flight op, including
// the output register, obeys branch squash / clear.
//
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-low reset
//   in_valid         issued op present
//   in_func          0=MUL 1=MULH 2=MULHSU 3=MULHU
//   in_rs1, in_rs2   operands
//   in_tag           destination physical register
//   in_b_mask        branch mask of the incoming op
//   br_id, br_task   resolving branch (one-hot), 0=NOTHING 1=SQUASH 2=CLEAR
//   cdb_grant        arbiter takes the output this cycle
//   busy             S[0] is full and cannot move (to RS fu_mult_busy)
//   out_valid        result waiting for the CDB
//   out_result       selected product bits
//   out_tag          destination tag
//   out_b_mask       current branch mask of the output op
module mult_fu #(
  parameter int XLEN    = 32,
  parameter int STAGES  = 4,
  parameter int PREG_W  = 6,
  parameter int BMASK_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [1:0]         in_func,
  input  logic [XLEN-1:0]    in_rs1,
  input  logic [XLEN-1:0]    in_rs2,
  input  logic [PREG_W-1:0]  in_tag,
  input  logic [BMASK_W-1:0] in_b_mask,
  input  logic [BMASK_W-1:0] br_id,
  input  logic [1:0]         br_task,
  input  logic               cdb_grant,
  output logic               busy,
  output logic               out_valid,
  output logic [XLEN-1:0]    out_result,
  output logic [PREG_W-1:0]  out_tag,
  output logic [BMASK_W-1:0] out_b_mask
);

  localparam int CW = XLEN / STAGES;  // rs2 bits consumed per stage
  localparam int AW = 2 * XLEN;       // accumulator width
  localparam int OW = XLEN + 1;       // extended operand width
  localparam int NS = STAGES - 1;     // accumulating stages before the output register

  localparam logic [1:0] FN_MUL    = 2'd0;
  localparam logic [1:0] FN_MULH   = 2'd1;
  localparam logic [1:0] FN_MULHSU = 2'd2;
  localparam logic [1:0] FN_MULHU  = 2'd3;
  localparam logic [1:0] BR_SQUASH = 2'd1;
  localparam logic [1:0] BR_CLEAR  = 2'd2;

  // Partial product of chunk idx of b, shifted into place. The top chunk
  // carries b's extension bit, so it is interpreted as signed; lower chunks
  // are unsigned. Everything wraps modulo 2^AW, which is exactly the
  // two's-complement product of the two XLEN+1-bit operands.
  function automatic logic [AW-1:0] partial_product(
    input logic [OW-1:0] a,
    input logic [OW-1:0] b,
    input int            idx
  );
    logic [AW-1:0] a_wide;
    logic [AW-1:0] chunk;
    a_wide = {{(AW-OW){a[OW-1]}}, a};
    if (idx == STAGES - 1) begin
      chunk = {{(AW-CW){b[OW-1]}}, b[idx*CW +: CW]};
    end else begin
      chunk = {{(AW-CW){1'b0}}, b[idx*CW +: CW]};
    end
    return (a_wide * chunk) << (idx * CW);
  endfunction

  // Accumulating stages S[0..NS-1]
  logic               valid_r [NS];
  logic [1:0]         func_r  [NS];
  logic [PREG_W-1:0]  tag_r   [NS];
  logic [BMASK_W-1:0] mask_r  [NS];
  logic [OW-1:0]      op_a_r  [NS];
  logic [OW-1:0]      op_b_r  [NS];
  logic [AW-1:0]      acc_r   [NS];

  // Output register S[STAGES-1]
  logic               out_valid_r;
  logic [XLEN-1:0]    out_result_r;
  logic [PREG_W-1:0]  out_tag_r;
  logic [BMASK_W-1:0] out_mask_r;

  logic [STAGES-1:0]  room_s;      // stage i can take new contents at the next edge
  logic [NS-1:0]      kill_s;      // stage i is hit by the current squash
  logic               out_kill_s;
  logic               in_kill_s;
  logic [BMASK_W-1:0] keep_s;      // mask bits that survive the current clear
  logic               ext_a_s;
  logic               ext_b_s;
  logic [OW-1:0]      in_a_s;
  logic [OW-1:0]      in_b_s;
  logic [AW-1:0]      last_sum_s;
  logic [XLEN-1:0]    result_s;

  // Room chain from the output back to S[0]: a stage has room when it is
  // empty or its occupant leaves, which lets bubbles collapse.
  always_comb begin
    logic r;
    room_s = {STAGES{1'b0}};
    r = !out_valid_r | cdb_grant;
    room_s[STAGES-1] = r;
    for (int i = NS - 1; i >= 0; i--) begin
      r = !valid_r[i] | r;
      room_s[i] = r;
    end
  end

  assign busy = valid_r[0] & !room_s[1];

  // Branch resolution: which entries die and which mask bits survive.
  always_comb begin
    keep_s     = (br_task == BR_CLEAR) ? ~br_id : {BMASK_W{1'b1}};
    in_kill_s  = (br_task == BR_SQUASH) && ((in_b_mask & br_id) != {BMASK_W{1'b0}});
    out_kill_s = (br_task == BR_SQUASH) && ((out_mask_r & br_id) != {BMASK_W{1'b0}});
    kill_s     = {NS{1'b0}};
    for (int i = 0; i < NS; i++) begin
      kill_s[i] = (br_task == BR_SQUASH) && ((mask_r[i] & br_id) != {BMASK_W{1'b0}});
    end
  end

  // Operand extension by function: rs1 signed for MULH/MULHSU, rs2 only for MULH.
  always_comb begin
    ext_a_s = 1'b0;
    ext_b_s = 1'b0;
    case (in_func)
      FN_MUL:    begin ext_a_s = 1'b0; ext_b_s = 1'b0; end
      FN_MULH:   begin ext_a_s = 1'b1; ext_b_s = 1'b1; end
      FN_MULHSU: begin ext_a_s = 1'b1; ext_b_s = 1'b0; end
      FN_MULHU:  begin ext_a_s = 1'b0; ext_b_s = 1'b0; end
      default:   begin ext_a_s = 1'b0; ext_b_s = 1'b0; end
    endcase
    in_a_s = {ext_a_s & in_rs1[XLEN-1], in_rs1};
    in_b_s = {ext_b_s & in_rs2[XLEN-1], in_rs2};
  end

  // Final accumulation and result selection for the op entering the output register.
  always_comb begin
    last_sum_s = acc_r[NS-1] + partial_product(op_a_r[NS-1], op_b_r[NS-1], NS);
    if (func_r[NS-1] == FN_MUL) begin
      result_s = last_sum_s[XLEN-1:0];
    end else begin
      result_s = last_sum_s[AW-1:XLEN];
    end
  end

  // Pipeline stage registers: load from upstream when there is room, else hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NS; i++) begin
        valid_r[i] <= 1'b0;
        func_r[i]  <= 2'd0;
        tag_r[i]   <= {PREG_W{1'b0}};
        mask_r[i]  <= {BMASK_W{1'b0}};
        op_a_r[i]  <= {OW{1'b0}};
        op_b_r[i]  <= {OW{1'b0}};
        acc_r[i]   <= {AW{1'b0}};
      end
    end else begin
      // S[0] takes the issued op; room_s[0] is exactly !busy.
      if (room_s[0]) begin
        valid_r[0] <= in_valid & !in_kill_s;
        if (in_valid) begin
          func_r[0] <= in_func;
          tag_r[0]  <= in_tag;
          mask_r[0] <= in_b_mask & keep_s;
          op_a_r[0] <= in_a_s;
          op_b_r[0] <= in_b_s;
          acc_r[0]  <= partial_product(in_a_s, in_b_s, 0);
        end
      end else begin
        valid_r[0] <= valid_r[0] & !kill_s[0];
        mask_r[0]  <= mask_r[0] & keep_s;
      end
      for (int i = 1; i < NS; i++) begin
        if (room_s[i]) begin
          valid_r[i] <= valid_r[i-1] & !kill_s[i-1];
          if (valid_r[i-1]) begin
            func_r[i] <= func_r[i-1];
            tag_r[i]  <= tag_r[i-1];
            mask_r[i] <= mask_r[i-1] & keep_s;
            op_a_r[i] <= op_a_r[i-1];
            op_b_r[i] <= op_b_r[i-1];
            acc_r[i]  <= acc_r[i-1] + partial_product(op_a_r[i-1], op_b_r[i-1], i);
          end
        end else begin
          valid_r[i] <= valid_r[i] & !kill_s[i];
          mask_r[i]  <= mask_r[i] & keep_s;
        end
      end
    end
  end

  // Output register: a granted result leaves even if squashed in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_r  <= 1'b0;
      out_result_r <= {XLEN{1'b0}};
      out_tag_r    <= {PREG_W{1'b0}};
      out_mask_r   <= {BMASK_W{1'b0}};
    end else if (room_s[STAGES-1]) begin
      out_valid_r <= valid_r[NS-1] & !kill_s[NS-1];
      if (valid_r[NS-1]) begin
        out_result_r <= result_s;
        out_tag_r    <= tag_r[NS-1];
        out_mask_r   <= mask_r[NS-1] & keep_s;
      end
    end else begin
      out_valid_r <= out_valid_r & !out_kill_s;
      out_mask_r  <= out_mask_r & keep_s;
    end
  end

  assign out_valid  = out_valid_r;
  assign out_result = out_result_r;
  assign out_tag    = out_tag_r;
  assign out_b_mask = out_mask_r;

endmodule

// File: doc/mult_fu.md
Name: mult_fu

Overview:
- Pipelined integer multiply functional unit sitting directly downstream of the reservation station.
- Consumes one issued multiply per cycle on the RS mult issue port and drives the matching fu_mult_busy bit back to the RS.
- Computes RV32M MUL/MULH/MULHSU/MULHU over STAGES pipeline stages, then holds the result in an output register until the CDB arbiter grants it.
- Honours branch-mask squash/clear on every in-flight op.

Parameters:
- XLEN, 32, operand/result width
- STAGES, 4, multiply pipeline depth, ≥2; XLEN divisible by STAGES
- PREG_W, 6, physical destination tag width
- BMASK_W, 4, branch mask width (one-hot br_id)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  issued op present
- in_func  in  2  0=MUL 1=MULH 2=MULHSU 3=MULHU
- in_rs1  in  XLEN  operand A
- in_rs2  in  XLEN  operand B
- in_tag  in  PREG_W  destination physical register
- in_b_mask  in  BMASK_W  op's branch mask
- br_id  in  BMASK_W  one-hot resolving branch
- br_task  in  2  0=NOTHING 1=SQUASH 2=CLEAR
- cdb_grant  in  1  arbiter accepts output this cycle
- busy  out  1  cannot accept an op this cycle (to RS fu_mult_busy)
- out_valid  out  1  result waiting for CDB
- out_result  out  XLEN  selected product bits
- out_tag  out  PREG_W  destination tag
- out_b_mask  out  BMASK_W  current branch mask of output

Behaviour:
- Stage registers S[0..STAGES-1], each holding: valid, func, tag, b_mask, operands, partial-product accumulator (2*XLEN).
- Operands are extended to XLEN+1 bits on capture:
  - sign-extend rs1 for MULH/MULHSU;
  - sign-extend rs2 for MULH only.
- Each stage adds XLEN/STAGES bits' worth of rs2 partial products into the 2*XLEN accumulator, with two's-complement wraparound.
- S[STAGES-1] is the output register.
- Result selection: MUL → low XLEN bits; all others → high XLEN bits.
- Advance rule:
  - out_ready = !S[last].valid | cdb_grant.
  - Stage i < last moves forward when S[i+1] is empty or moves forward (bubbles collapse).
  - A stage that does not move holds its contents.
- busy = S[0].valid & !S[0] moving. It is combinational on cdb_grant and registers only; it never depends on in_valid.
- Accept: when in_valid & !busy, S[0] loads at the next edge. If in_valid & busy, the op is ignored; it is the RS's job not to issue.
- Minimum latency: accepted at edge T → out_valid high after edge T+STAGES-1. With an always-granting CDB, throughput is 1/cycle.
- Output handshake: out_valid is high iff S[last].valid. It drops after the edge where cdb_grant was high, unless a new op advances in. out_* are stable while out_valid & !cdb_grant.
- SQUASH: every stage (including the output register) with (b_mask & br_id) != 0 is invalidated at the next edge. An incoming op whose in_b_mask hits br_id is not loaded. busy for that cycle is still computed from pre-squash state.
- CLEAR: br_id bit is cleared in every stage's b_mask and in an incoming op's mask at the next edge. out_b_mask reflects the cleared mask from the following cycle.
- NOTHING / unused encoding 3: no mask effect.
- Simultaneous grant + squash on the output register: the grant is consumed (arbiter already took it) and the register empties. No double effect.
- Reset (asserted low, any time, asynchronous): all valid bits cleared, so out_valid=0 and busy=0. Data fields are don't-care, but out_result/out_tag/out_b_mask read 0. In-flight ops are lost. Operation resumes on the first edge after deassertion.

Test Plan:
- Single op: MUL rs1=7 rs2=6 tag=5, grant held high → out_valid exactly 3 edges after accept edge (STAGES=4), result=42, tag=5; busy never asserted.
- High variants:
  - MULH 0xFFFFFFFF×0xFFFFFFFF → 0;
  - MULHU same operands → 0xFFFFFFFE;
  - MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF;
  - MUL 0x80000000×2 → 0.
- Back-pressure: stream 6 back-to-back ops with cdb_grant=0 → busy rises once all 4 stages are full, out_* stable. Then grant 1 → results drain in order one per cycle, busy falls the same cycle grant rises.
- Squash: ops with b_mask 0001, 0010, 0001 in flight, SQUASH br_id=0001 → only the 0010 op emerges. Same cycle, an incoming op with mask 0001 is not accepted into the pipeline.
- Clear: op with b_mask 0011 in flight, CLEAR br_id=0010 → out_b_mask=0001 at output. A later SQUASH br_id=0010 leaves it intact.
- Async reset mid-stream: pull reset low between edges with 3 ops in flight → out_valid and busy go 0 immediately without a clock edge. After release, a new MUL 3×3 → 9 with normal latency.
